// File: rtl/uart_rx_word.sv
// UART 8N1 receiver packing consecutive bytes little-endian into
// DATA_WIDTH words delivered on an AXI-Stream master port.
module uart_rx_word #(
   parameter int DATA_WIDTH  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  rxd,
   input  logic [15:0]           prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  busy,
   output logic                  overrun_error,
   output logic                  frame_error
);

   localparam int NB = DATA_WIDTH / 8;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   rxs;
   logic [15:0]            p_q;
   logic [15:0]            p_eff;
   logic [18:0]            cnt_q, cnt_d;
   logic [18:0]            half_ld, full_ld;
   logic [2:0]             idx_q, idx_d;
   logic [7:0]             sh_q;
   logic [BW-1:0]          bcnt_q;
   logic [DATA_WIDTH-1:0]  word_q, word_full;
   logic                   expire, shift_en;
   logic                   byte_ok, byte_bad, word_done;

   assign rxs     = sync_q[SYNC_STAGES-1];
   assign busy    = (state_q != IDLE);
   assign p_eff   = (prescale == 16'd0) ? 16'd1 : prescale;
   assign half_ld = {1'b0, p_eff, 2'b00} - 19'd1;
   assign full_ld = {p_q, 3'b000} - 19'd1;
   assign expire  = (cnt_q == 19'd0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      shift_en = 1'b0;
      byte_ok  = 1'b0;
      byte_bad = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!rxs) begin
               state_d = START;
               cnt_d   = half_ld;
            end
         end
         START: begin
            if (!expire) begin
               cnt_d = cnt_q - 19'd1;
            end else if (rxs) begin
               state_d = IDLE;
            end else begin
               state_d = DATA;
               idx_d   = 3'd0;
               cnt_d   = full_ld;
            end
         end
         DATA: begin
            if (!expire) begin
               cnt_d = cnt_q - 19'd1;
            end else begin
               shift_en = 1'b1;
               cnt_d    = full_ld;
               idx_d    = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = STOP;
            end
         end
         STOP: begin
            if (!expire) begin
               cnt_d = cnt_q - 19'd1;
            end else begin
               state_d  = IDLE;
               byte_ok  = rxs;
               byte_bad = !rxs;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign word_done = byte_ok && (bcnt_q == BW'(NB - 1));

   // sh_q already holds the full byte when the stop bit is sampled
   always_comb begin
      word_full = word_q;
      for (int k = 0; k < NB; k++) begin
         if (bcnt_q == BW'(k)) word_full[8*k +: 8] = sh_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q  <= '1;
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         p_q     <= 16'd1;
         sh_q    <= '0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], rxd};
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         if (state_q == IDLE && !rxs) p_q <= p_eff;
         if (shift_en) sh_q <= {rxs, sh_q[7:1]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcnt_q <= '0;
         word_q <= '0;
      end else if (byte_bad || word_done) begin
         bcnt_q <= '0;
         word_q <= '0;
      end else if (byte_ok) begin
         bcnt_q <= bcnt_q + BW'(1);
         word_q <= word_full;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         overrun_error <= 1'b0;
         frame_error   <= 1'b0;
      end else begin
         overrun_error <= 1'b0;
         frame_error   <= byte_bad;
         if (m_axis_tvalid && m_axis_tready) m_axis_tvalid <= 1'b0;
         if (word_done) begin
            if (!m_axis_tvalid || m_axis_tready) begin
               m_axis_tdata  <= word_full;
               m_axis_tvalid <= 1'b1;
            end else begin
               overrun_error <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_word.sv
// Bench for uart_rx_word: directed frames plus random words checked
// against a byte-level little-endian packing model.
module tb_uart_rx_word;

   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          rxd = 1'b1;
   logic          tready = 1'b0;
   logic [15:0]   prescale = 16'd4;
   logic [DW-1:0] tdata;
   logic          tvalid, busy, ovr, fe;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int tv_cnt = 0;
   int ovr_cnt = 0;
   int fe_cnt = 0;
   int busy_cnt = 0;
   int rise_cyc = -1;
   int last_start = 0;
   logic tv_prev = 1'b0;
   logic [DW-1:0] got[$];

   always #5 clk = ~clk;

   uart_rx_word #(.DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .rxd           (rxd),
      .prescale      (prescale),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .busy          (busy),
      .overrun_error (ovr),
      .frame_error   (fe)
   );

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tvalid && !tv_prev) rise_cyc <= cyc;
      tv_prev <= tvalid;
      if (tvalid) tv_cnt <= tv_cnt + 1;
      if (tvalid && tready) got.push_back(tdata);
      if (ovr) ovr_cnt <= ovr_cnt + 1;
      if (fe) fe_cnt <= fe_cnt + 1;
      if (busy) busy_cnt <= busy_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] gw(input int i);
      return (i < got.size()) ? got[i] : 'x;
   endfunction

   function automatic int peff();
      return (prescale == 16'd0) ? 1 : int'(prescale);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input int n);
      rxd = v;
      repeat (n) tick();
   endtask

   task automatic send_byte(input logic [7:0] b, input logic sv);
      int l;
      l = 8 * peff();
      last_start = cyc;
      drive(1'b0, l);
      for (int i = 0; i < 8; i++) drive(b[i], l);
      drive(sv, l);
      if (!sv) drive(1'b1, 2 * l);
   endtask

   task automatic send_word(input logic [DW-1:0] w);
      for (int k = 0; k < DW / 8; k++) send_byte(w[8*k +: 8], 1'b1);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tvalid"}, tvalid, 0);
      chk({tag, "_tdata"}, tdata, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_ovr"}, ovr, 0);
      chk({tag, "_fe"}, fe, 0);
   endtask

   initial begin
      int base, o0, f0, t0, b0, nexp, ncur;
      logic [DW-1:0] accw;
      logic [7:0] rb;
      logic [DW-1:0] expq[$];

      repeat (3) tick();
      chk_reset("rst");
      rst_n = 1'b1;
      tready = 1'b1;
      repeat (5) tick();

      // single word, timing of the beat
      base = got.size(); o0 = ovr_cnt; f0 = fe_cnt; t0 = tv_cnt;
      send_word(32'h12345678);
      repeat (20) tick();
      chk("t1_count", got.size() - base, 1);
      chk("t1_word", gw(base), 32'h12345678);
      chk("t1_tv_cycles", tv_cnt - t0, 1);
      chk("t1_latency", rise_cyc - last_start, 76 * 4 + 3);
      chk("t1_ovr", ovr_cnt - o0, 0);
      chk("t1_fe", fe_cnt - f0, 0);

      // overrun while the held word is not accepted
      tready = 1'b0;
      base = got.size(); o0 = ovr_cnt;
      send_word(32'h12345678);
      send_word(32'hDEADBEEF);
      repeat (20) tick();
      chk("t2_tvalid", tvalid, 1);
      chk("t2_tdata", tdata, 32'h12345678);
      chk("t2_ovr", ovr_cnt - o0, 1);
      tready = 1'b1;
      repeat (3) tick();
      chk("t2_count", got.size() - base, 1);
      chk("t2_word", gw(base), 32'h12345678);
      chk("t2_tvalid_drop", tvalid, 0);

      // framing error discards the partial word
      base = got.size(); o0 = ovr_cnt; f0 = fe_cnt;
      send_byte(8'hAA, 1'b1);
      send_byte(8'h55, 1'b0);
      send_word(32'h44332211);
      repeat (20) tick();
      chk("t3_fe", fe_cnt - f0, 1);
      chk("t3_count", got.size() - base, 1);
      chk("t3_word", gw(base), 32'h44332211);
      chk("t3_ovr", ovr_cnt - o0, 0);

      // one-cycle glitch is a false start
      base = got.size(); o0 = ovr_cnt; f0 = fe_cnt; b0 = busy_cnt;
      drive(1'b0, 1);
      drive(1'b1, 60);
      chk("t4_busy_seen", (busy_cnt - b0) >= 1, 1);
      chk("t4_busy_short", (busy_cnt - b0) <= 4 * 4 + 1, 1);
      chk("t4_busy_end", busy, 0);
      chk("t4_count", got.size() - base, 0);
      chk("t4_err", (ovr_cnt - o0) + (fe_cnt - f0), 0);

      // prescale 0 acts as 1, back-to-back frames
      prescale = 16'd0;
      repeat (4) tick();
      base = got.size();
      accw = DW'($urandom);
      send_word(32'h04030201);
      chk("t5_latency", rise_cyc - last_start, 76 + 3);
      send_word(accw);
      repeat (20) tick();
      chk("t5_count", got.size() - base, 2);
      chk("t5_word0", gw(base), 32'h04030201);
      chk("t5_word1", gw(base + 1), accw);

      // random bytes with occasional bad stop bits
      prescale = 16'($urandom_range(1, 3));
      repeat (4) tick();
      base = got.size(); f0 = fe_cnt; o0 = ovr_cnt;
      nexp = 0; ncur = 0; accw = '0;
      for (int n = 0; n < 24 || ncur != 0; n++) begin
         logic sv;
         rb = 8'($urandom);
         sv = (n >= 24) || ($urandom_range(0, 7) != 0);
         send_byte(rb, sv);
         if (!sv) begin
            nexp++;
            ncur = 0;
            accw = '0;
         end else begin
            accw = accw | (DW'(rb) << (8 * ncur));
            ncur++;
            if (ncur == DW / 8) begin
               expq.push_back(accw);
               ncur = 0;
               accw = '0;
            end
         end
      end
      repeat (20) tick();
      chk("rnd_fe", fe_cnt - f0, nexp);
      chk("rnd_ovr", ovr_cnt - o0, 0);
      chk("rnd_count", got.size() - base, expq.size());
      foreach (expq[i]) chk("rnd_word", gw(base + i), expq[i]);

      // reset mid-frame with a pending word
      prescale = 16'd2;
      tready = 1'b0;
      repeat (4) tick();
      send_word(32'hCAFEF00D);
      repeat (5) tick();
      chk("t6_pending", tvalid, 1);
      send_byte(8'h9A, 1'b1);
      send_byte(8'hBC, 1'b1);
      drive(1'b0, 16);
      for (int i = 0; i < 3; i++) drive(1'($urandom), 16);
      rst_n = 1'b0;
      #1;
      chk_reset("t6_rst");
      repeat (3) tick();
      rxd = 1'b1;
      rst_n = 1'b1;
      tready = 1'b1;
      repeat (5) tick();
      base = got.size(); o0 = ovr_cnt; f0 = fe_cnt;
      send_word(32'h0BADF00D);
      repeat (20) tick();
      chk("t6_count", got.size() - base, 1);
      chk("t6_word", gw(base), 32'h0BADF00D);
      chk("t6_err", (ovr_cnt - o0) + (fe_cnt - f0), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
